// File: rtl/lock_keyer.sv
// lock_keyer: sends a three-byte unlock sequence to a lock, waits for the lock's
// unlocked status and retries up to MAX_TRIES times before reporting failure.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - asynchronous active-high reset
//   start     - request one unlock transaction (sampled only when idle)
//   abort     - cancel the transaction in progress (ignored when idle)
//   unlocked  - lock status, honoured only while waiting
//   code      - registered byte presented to the lock
//   busy      - high whenever a transaction is in progress
//   done      - one-cycle pulse, lock reported unlocked
//   fail      - one-cycle pulse, every attempt timed out
//   attempt   - current attempt number (1-based while busy, held when idle)
module lock_keyer #(
  parameter logic [7:0]  CODE0     = 8'hAA,
  parameter logic [7:0]  CODE1     = 8'hBB,
  parameter logic [7:0]  CODE2     = 8'hCC,
  parameter logic [7:0]  FILL      = 8'h00,
  parameter int unsigned HOLD      = 1,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       unlocked,
  output logic [7:0] code,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] attempt
);

  typedef enum logic [2:0] {StIdle, StSend0, StSend1, StSend2, StWait} state_e;

  localparam logic [7:0]  HoldLast = 8'(HOLD - 1);
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);
  localparam logic [3:0]  MaxTries = 4'(MAX_TRIES);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] wait_q, wait_d;
  logic [3:0]  attempt_q, attempt_d;
  logic [7:0]  code_q, code_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  // Shared byte-hold step for the three SEND states.
  function automatic logic hold_expired(logic [7:0] cnt);
    return cnt == HoldLast;
  endfunction

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wait_d    = wait_q;
    attempt_d = attempt_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;

    if (state_q != StIdle && abort) begin
      // Abort outranks both unlocked and timeout.
      state_d = StIdle;
      hold_d  = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StSend0;
            attempt_d = 4'd1;
            hold_d    = '0;
          end
        end
        StSend0, StSend1, StSend2: begin
          if (hold_expired(hold_q)) begin
            hold_d  = '0;
            state_d = (state_q == StSend0) ? StSend1 :
                      (state_q == StSend1) ? StSend2 : StWait;
            wait_d  = '0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        StWait: begin
          if (unlocked) begin
            // Success wins even in the final wait cycle.
            state_d = StIdle;
            done_d  = 1'b1;
            wait_d  = '0;
          end else if (wait_q == WaitLast) begin
            wait_d = '0;
            if (attempt_q < MaxTries) begin
              state_d   = StSend0;
              attempt_d = attempt_q + 4'd1;
              hold_d    = '0;
            end else begin
              state_d = StIdle;
              fail_d  = 1'b1;
            end
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end
        default: begin
          state_d = StIdle;
          hold_d  = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Code register follows the state being entered, so bytes are contiguous.
  always_comb begin
    code_d = FILL;
    unique case (state_d)
      StSend0: code_d = CODE0;
      StSend1: code_d = CODE1;
      StSend2: code_d = CODE2;
      default: code_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      wait_q    <= '0;
      attempt_q <= '0;
      code_q    <= FILL;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      attempt_q <= attempt_d;
      code_q    <= code_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign code    = code_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign fail    = fail_q;
  assign attempt = attempt_q;

endmodule

// File: tb/tb_lock_keyer.sv
// Bench for lock_keyer: DUT 0 uses HOLD=2/TIMEOUT=8, DUT 1 uses HOLD=1/TIMEOUT=1,
// both MAX_TRIES=3. A timeline model (cycle offset within a transaction) predicts
// every output each cycle.
module tb_lock_keyer;

  localparam int MaxTries = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_r [2];
  logic       abort_r [2];
  logic       unl_r   [2];
  logic [7:0] code_w  [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       fail_w  [2];
  logic [3:0] att_w   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: active flag, cycles since first SEND0 cycle, last attempt.
  bit       m_act  [2];
  int       m_t    [2];
  logic [3:0] m_att [2];
  bit       m_done [2];
  bit       m_fail [2];

  always #5 clk = ~clk;

  lock_keyer #(.HOLD(2), .TIMEOUT(8), .MAX_TRIES(MaxTries)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_r[0]), .abort(abort_r[0]),
    .unlocked(unl_r[0]), .code(code_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .fail(fail_w[0]), .attempt(att_w[0])
  );

  lock_keyer #(.HOLD(1), .TIMEOUT(1), .MAX_TRIES(MaxTries)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_r[1]), .abort(abort_r[1]),
    .unlocked(unl_r[1]), .code(code_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .fail(fail_w[1]), .attempt(att_w[1])
  );

  function automatic int hold_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int tmo_of(int d);
    return (d == 0) ? 8 : 1;
  endfunction

  function automatic logic [7:0] exp_code(int d);
    int h = hold_of(d);
    int l = 3 * h + tmo_of(d);
    int pos;
    if (!m_act[d]) return 8'h00;
    pos = m_t[d] % l;
    if (pos >= 3 * h) return 8'h00;
    case (pos / h)
      0:       return 8'hAA;
      1:       return 8'hBB;
      default: return 8'hCC;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_t[d] = 0; m_att[d] = 4'd0; m_done[d] = 0; m_fail[d] = 0;
    end
  endtask

  task automatic model_step(int d);
    int h = hold_of(d);
    int l = 3 * h + tmo_of(d);
    int pos;
    m_done[d] = 0;
    m_fail[d] = 0;
    if (!m_act[d]) begin
      if (start_r[d]) begin
        m_act[d] = 1; m_t[d] = 0; m_att[d] = 4'd1;
      end
    end else if (abort_r[d]) begin
      m_act[d] = 0;
    end else begin
      pos = m_t[d] % l;
      if (pos >= 3 * h && unl_r[d]) begin
        m_act[d] = 0; m_done[d] = 1;
      end else if (pos == l - 1 && m_t[d] / l + 1 == MaxTries) begin
        m_act[d] = 0; m_fail[d] = 1;
      end else begin
        m_t[d]++;
        m_att[d] = 4'(m_t[d] / l + 1);
      end
    end
  endtask

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d code", d),    16'(code_w[d]), 16'(exp_code(d)));
      check($sformatf("d%0d busy", d),    16'(busy_w[d]), 16'(m_act[d]));
      check($sformatf("d%0d done", d),    16'(done_w[d]), 16'(m_done[d]));
      check($sformatf("d%0d fail", d),    16'(fail_w[d]), 16'(m_fail[d]));
      check($sformatf("d%0d attempt", d), 16'(att_w[d]),  16'(m_att[d]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      start_r[d] = 0; abort_r[d] = 0; unl_r[d] = 0;
    end
  endtask

  int cnt;

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    #2;
    check_all();
    #10;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Success on the 3rd WAIT cycle, explicit byte sequence on DUT 0.
    start_r[0] = 1; abort_r[0] = 1;  // start wins over abort in IDLE
    tick();
    start_r[0] = 0; abort_r[0] = 0;
    check("seq0 code", 16'(code_w[0]), 16'h00AA);
    check("seq0 attempt", 16'(att_w[0]), 16'd1);
    tick(); check("seq1 code", 16'(code_w[0]), 16'h00AA);
    tick(); check("seq2 code", 16'(code_w[0]), 16'h00BB);
    tick(); check("seq3 code", 16'(code_w[0]), 16'h00BB);
    tick(); check("seq4 code", 16'(code_w[0]), 16'h00CC);
    tick(); check("seq5 code", 16'(code_w[0]), 16'h00CC);
    tick(); check("wait0 code", 16'(code_w[0]), 16'h0000);
    tick(); tick();
    unl_r[0] = 1;
    tick();
    unl_r[0] = 0;
    check("done pulse", 16'(done_w[0]), 16'd1);
    check("busy after done", 16'(busy_w[0]), 16'd0);
    tick();
    check("done single", 16'(done_w[0]), 16'd0);

    // All attempts time out: fail 42 cycles after first SEND0 cycle.
    start_r[0] = 1;
    tick();
    start_r[0] = 0;
    cnt = 0;
    while (!fail_w[0] && cnt < 60) begin
      tick();
      cnt++;
    end
    check("fail offset", 16'(cnt), 16'd42);
    check("fail attempt", 16'(att_w[0]), 16'd3);
    tick();
    check("fail single", 16'(fail_w[0]), 16'd0);
    check("attempt held idle", 16'(att_w[0]), 16'd3);

    // Abort in the second SEND1 cycle.
    start_r[0] = 1;
    tick();
    start_r[0] = 0;
    repeat (3) tick();
    abort_r[0] = 1; unl_r[0] = 1;
    tick();
    abort_r[0] = 0; unl_r[0] = 0;
    check("abort code", 16'(code_w[0]), 16'h0000);
    check("abort busy", 16'(busy_w[0]), 16'd0);
    check("abort done", 16'(done_w[0]), 16'd0);

    // Unlock on the final WAIT cycle wins; then unlocked during SEND1 is ignored.
    start_r[0] = 1;
    tick();
    start_r[0] = 0;
    repeat (13) tick();
    unl_r[0] = 1;
    tick();
    unl_r[0] = 0;
    check("last wait done", 16'(done_w[0]), 16'd1);
    check("last wait attempt", 16'(att_w[0]), 16'd1);
    start_r[0] = 1;
    tick();
    start_r[0] = 0;
    tick(); tick();
    unl_r[0] = 1;
    tick(); tick();
    unl_r[0] = 0;
    check("send ignores unlocked", 16'(done_w[0]), 16'd0);
    check("still sending", 16'(code_w[0]), 16'h00CC);

    // Asynchronous reset mid-WAIT (now in WAIT), checked before the next edge.
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_r[0] = 1;
    tick();
    start_r[0] = 0;
    check("restart attempt", 16'(att_w[0]), 16'd1);
    check("restart code", 16'(code_w[0]), 16'h00AA);
    abort_r[0] = 1;
    tick();
    abort_r[0] = 0;

    // HOLD=1, TIMEOUT=1 on DUT 1: AA,BB,CC then a single WAIT cycle per attempt.
    start_r[1] = 1;
    tick();
    start_r[1] = 0;
    check("h1 code0", 16'(code_w[1]), 16'h00AA);
    tick(); check("h1 code1", 16'(code_w[1]), 16'h00BB);
    tick(); check("h1 code2", 16'(code_w[1]), 16'h00CC);
    tick(); check("h1 wait", 16'(code_w[1]), 16'h0000);
    tick(); check("h1 retry", 16'(code_w[1]), 16'h00AA);
    check("h1 retry attempt", 16'(att_w[1]), 16'd2);
    repeat (8) tick();

    // Randomized segments on both DUTs with differing input biases.
    for (int seg = 0; seg < 40; seg++) begin
      int mode = $urandom_range(0, 3);
      for (int c = 0; c < 30; c++) begin
        for (int d = 0; d < 2; d++) begin
          start_r[d] = ($urandom_range(0, 3) == 0);
          abort_r[d] = (mode == 2) ? ($urandom_range(0, 19) == 0) :
                       (mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
          unl_r[d]   = (mode == 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
        end
        tick();
      end
    end
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lock_keyer.md
LOCK_KEYER -- requirements
Module: lock_keyer

Interface
REQ-001 Parameter CODE0, default 8'hAA, first byte of the unlock sequence.
REQ-002 Parameter CODE1, default 8'hBB, second byte of the unlock sequence.
REQ-003 Parameter CODE2, default 8'hCC, third byte of the unlock sequence.
REQ-004 Parameter FILL, default 8'h00, byte driven on code when no sequence byte is being sent.
REQ-005 Parameter HOLD, default 1, number of cycles each sequence byte is held on code; legal range 1..255.
REQ-006 Parameter TIMEOUT, default 16, number of WAIT cycles allowed for unlocked; legal range 1..65535.
REQ-007 Parameter MAX_TRIES, default 3, total number of sequence attempts before failure; legal range 1..15.
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 reset  input  1  reset; asynchronous, active-high.
REQ-010 start  input  1  request to send one unlock sequence; sampled only in IDLE.
REQ-011 abort  input  1  cancel the transaction in progress; honoured in any non-IDLE state.
REQ-012 unlocked  input  1  status from the lock; honoured only in WAIT.
REQ-013 code  output  8  registered byte presented to the lock.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse: lock reported unlocked.
REQ-016 fail  output  1  one-cycle pulse: all attempts timed out.
REQ-017 attempt  output  4  current attempt number; 1-based while busy.

Function
REQ-018 The FSM SHALL have the states IDLE, SEND0, SEND1, SEND2 and WAIT.
REQ-019 When IDLE samples start=1, the FSM SHALL enter SEND0 on the next cycle, with attempt=1 and code=CODE0 in that cycle.
REQ-020 SENDn SHALL last exactly HOLD cycles, holding code=CODEn and advancing SEND0->SEND1->SEND2->WAIT.
REQ-021 Sequence bytes SHALL be contiguous: the first SEND1 cycle immediately follows the last SEND0 cycle, with no FILL cycle between.
REQ-022 In WAIT, code SHALL be FILL and a wait counter SHALL run from 0.
REQ-023 When WAIT samples unlocked=1, the next cycle SHALL have done=1, state=IDLE, busy=0 and code=FILL.
REQ-024 After TIMEOUT WAIT cycles without unlocked=1, the FSM SHALL retry or fail according to REQ-025 and REQ-026.
REQ-025 On timeout with attempt<MAX_TRIES, the next cycle SHALL be SEND0 with attempt incremented.
REQ-026 On timeout with attempt=MAX_TRIES, the next cycle SHALL have fail=1 and state=IDLE.
REQ-027 If unlocked=1 in the final WAIT cycle, success SHALL win and no retry or fail SHALL occur.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE and code=FILL next cycle, with no done or fail pulse.
REQ-029 abort SHALL take priority over unlocked and over timeout.
REQ-030 start SHALL be ignored while busy=1, and abort SHALL be ignored in IDLE.
REQ-031 If start and abort are both 1 in IDLE, start SHALL be accepted.
REQ-032 In IDLE, attempt SHALL hold its last value until the next accepted start; done and fail SHALL never be high in the same cycle.
REQ-033 The hold counter SHALL be 8 bits and the wait counter 16 bits; neither counter SHALL wrap within a state.

Reset
REQ-034 While reset=1, the block SHALL asynchronously force state=IDLE, code=FILL, busy=0, done=0, fail=0, attempt=0 and clear both counters.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no done or fail pulse.
REQ-036 After reset is released, the first start SHALL behave exactly as REQ-019.

Verification (HOLD=2, TIMEOUT=8, MAX_TRIES=3 unless noted)
REQ-037 Pulse start, then assert unlocked 3 cycles into WAIT -> code sequence AA,AA,BB,BB,CC,CC,00..., with done=1 exactly once, one cycle after unlocked is sampled, and busy=0 afterwards.
REQ-038 Pulse start and hold unlocked=0 -> three full sequences with attempt stepping 1,2,3, then fail=1 for one cycle exactly 3*(6+8) cycles after the first SEND0 cycle.
REQ-039 Assert abort in the second SEND1 cycle -> code=00, busy=0 and done=fail=0 on the next cycle.
REQ-040 Assert unlocked in the 8th WAIT cycle of attempt 1 -> done=1 and no retry; then assert unlocked during SEND1 -> unlocked is ignored.
REQ-041 Assert reset asynchronously mid-WAIT -> all outputs reach their reset values before the next clk edge; a subsequent start restarts at attempt=1.
REQ-042 With HOLD=1 and TIMEOUT=1, exercise all paths -> AA, BB, CC on consecutive cycles, followed by a single WAIT cycle.
